// File: rtl/encoding_rx_collector.sv
// rtl/encoding_rx_collector.sv - reassembles index-tagged elements into one parallel frame vector
module encoding_rx_collector #(
  parameter int LAST_COUNT = 6,
  parameter int DATA_WIDTH = 8,
  localparam int IW = (LAST_COUNT > 0) ? $clog2(LAST_COUNT + 1) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic [IW-1:0]                      i_in_index,
  input  logic [DATA_WIDTH-1:0]              i_in_data,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [(LAST_COUNT+1)*DATA_WIDTH-1:0] o_out_vector,
  output logic                               o_seq_error,
  output logic [15:0]                        o_frame_count
);

  localparam logic [IW-1:0] LAST_IDX = IW'(LAST_COUNT);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t                                r_state;
  logic [IW-1:0]                         r_expected;
  logic                                  r_in_ready;
  logic                                  r_out_valid;
  logic                                  r_seq_error;
  logic [15:0]                           r_frame_count;
  logic [(LAST_COUNT+1)*DATA_WIDTH-1:0]  r_vector;

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_out_valid;
  assign o_seq_error   = r_seq_error;
  assign o_frame_count = r_frame_count;
  assign o_out_vector  = r_vector;

  // Frame FSM: collect in-order elements, hold the finished vector until the consumer takes it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_COLLECT;
      r_expected    <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_seq_error   <= 1'b0;
      r_frame_count <= '0;
      r_vector      <= '0;
    end else begin
      r_seq_error <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (i_in_valid) begin
            if (i_in_index == r_expected) begin
              for (int k = 0; k <= LAST_COUNT; k++) begin
                if (IW'(k) == r_expected) begin
                  r_vector[k*DATA_WIDTH +: DATA_WIDTH] <= i_in_data;
                end
              end
              if (r_expected == LAST_IDX) begin
                r_expected  <= '0;
                r_state     <= S_HOLD;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
              end else begin
                r_expected <= r_expected + IW'(1);
              end
            end else begin
              // A stray index 0 is taken as the start of a fresh frame rather than thrown away
              r_seq_error <= 1'b1;
              if (i_in_index == '0) begin
                r_vector[0 +: DATA_WIDTH] <= i_in_data;
                r_expected                <= IW'(1);
              end else begin
                r_expected <= '0;
              end
            end
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_state       <= S_COLLECT;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        default: begin
          r_state     <= S_COLLECT;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/encoding_rx_collector.md
# encoding_rx_collector

Receive-side counterpart of the encoding counter: accepts a stream of index-tagged elements produced by an encoder whose element index is driven by `Counter`, checks that indices arrive in order 0..LAST_COUNT, and reassembles them into one parallel vector per frame. The block sits downstream of the encoding stage and presents each complete vector to the GNN layer through a valid/ready handshake. Out-of-order indices are flagged and the partial frame is discarded.

## Interface
- LAST_COUNT, 6: highest element index; each frame holds LAST_COUNT+1 elements, indices 0..LAST_COUNT.
- DATA_WIDTH, 8: width of one element.
- IW (localparam): $clog2(LAST_COUNT+1), the index width. This matches the encoder counter width.
- clk  input  1  the only clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an element is presented.
- in_ready  output  1  the block can accept an element.
- in_index  input  IW  index tag of the presented element.
- in_data  input  DATA_WIDTH  element value.
- out_valid  output  1  out_vector holds a complete frame.
- out_ready  input  1  the consumer accepts the frame.
- out_vector  output  (LAST_COUNT+1)*DATA_WIDTH  assembled frame; slot k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- seq_error  output  1  one-cycle pulse when an accepted element has an unexpected index.
- frame_count  output  16  number of frames delivered; wraps modulo 2^16.

## Operation
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Register `expected` (width IW) holds the next required index. Reset value is 0.
- An input transfer occurs when in_valid && in_ready.
- Transfer with in_index == expected:
  - Write in_data into slot `expected`.
  - If expected == LAST_COUNT: set expected=0 and move to HOLD.
  - Otherwise: expected = expected+1.
- Transfer with in_index != expected:
  - Assert seq_error for the next cycle and discard the partial frame.
  - If in_index == 0: treat the element as the start of a new frame. Write slot 0 and set expected=1.
  - Otherwise: set expected=0 and do not write.
- Index values above LAST_COUNT are always mismatches.
- HOLD: out_vector is stable while out_valid=1. On out_valid && out_ready, return to COLLECT and increment frame_count by 1.
- Slots are overwritten in place. A delivered frame always contains only elements from the current frame, because every index must arrive in order before HOLD is entered.
- Reset values, with reset taking priority over all other activity:
  - state=COLLECT, expected=0.
  - in_ready=1 in the cycle after reset deasserts.
  - out_valid=0, seq_error=0, frame_count=0, out_vector=0.
- Reset mid-frame or during HOLD: the partial or held frame is dropped silently. seq_error stays 0.

## Timing
- Input transfers: at most one per cycle.
- Latency: if the LAST_COUNT element is accepted at edge N, out_valid=1 after edge N and out_vector is valid in the same cycle.
- out_valid stays high until the cycle in which out_ready=1.
- On the handshake edge:
  - out_valid falls and in_ready rises after that edge.
  - No input is accepted in the handshake cycle, because in_ready=0 throughout HOLD.
- Minimum frame period: LAST_COUNT+2 cycles (LAST_COUNT+1 accepts plus 1 HOLD cycle with out_ready=1).
- seq_error: registered, high exactly one cycle after the offending edge. Back-to-back errors give back-to-back pulses.
- frame_count updates on the handshake edge.
- in_valid while in_ready=0: ignored. The upstream side must hold its data.

## Test plan
- **Clean frame.** Reset, then send indices 0..6 with data 0x10..0x16 on consecutive cycles, out_ready=1.
  - out_valid high for 1 cycle, after the edge that accepts index 6.
  - out_vector = 0x16151413121110.
  - frame_count=1, seq_error never asserted.
- **Backpressure.** Complete a frame with out_ready=0 for 5 cycles, then 1.
  - out_valid held 6 cycles with out_vector unchanged.
  - in_ready=0 throughout, and in_valid pulses in that window are not accepted.
  - frame_count increments once.
- **Sequence error.** Send indices 0,1,3.
  - seq_error pulses once after the edge accepting index 3.
  - A following 0..6 (data 0x20..0x26) delivers 0x26252423222120.
- **Error on index 0.** Send 0,1,2,0,1,...,6.
  - seq_error pulses once, after the second 0.
  - The frame delivered uses data from the second run only.
  - frame_count=1.
- **Out-of-range index.** Send in_index=7 during COLLECT.
  - seq_error pulse, expected returns to 0, no slot written.
- **Reset mid-operation.** Assert reset after index 3 is accepted; also repeat the test with reset during HOLD.
  - All outputs return to their reset values.
  - A subsequent full frame 0..6 delivers correctly with frame_count=1.
